// File: rtl/cla_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead word adder.
//   state_t         : sequencer FSM states (IDLE, RUN, DONE)
//   CLA_N_DEFAULT   : default slice width in bits
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CLA_N_DEFAULT = 4;

endpackage : cla_pkg

// File: rtl/cla_slice.sv
// N-bit combinational carry-lookahead adder slice.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of bit N-1
//   cmsb  : carry into bit N-1 (used for signed-overflow detection)
module cla_slice #(
  parameter int N = cla_pkg::CLA_N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is built directly as a sum of products over the generate and
  // propagate terms below it, so no carry depends on another carry.
  function automatic logic [N:0] lookahead(input logic [N-1:0] gen,
                                           input logic [N-1:0] prop,
                                           input logic         c0);
    logic [N:0] cc;
    logic       run_p;
    // NOTE: every bit of cc gets a value before any conditional use, so the
    // logic stays purely combinational with no inferred storage.
    cc    = '0;
    cc[0] = c0;
    for (int i = 0; i < N; i++) begin
      run_p = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cc[i+1] = cc[i+1] | (gen[j] & run_p);
        run_p   = run_p & prop[j];
      end
      cc[i+1] = cc[i+1] | (c0 & run_p);
    end
    return cc;
  endfunction

  assign c    = lookahead(g, p, cin);
  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
  assign cmsb = c[N-1];

endmodule : cla_slice

// File: rtl/cla_word_sequencer.sv
// Multi-cycle W-bit adder (W = N*K) that reuses one N-bit CLA slice K times,
// least-significant slice first, with a carry register between cycles.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : operand handshake (in_ready is registered)
//   a, b, cin             : W-bit operands and carry into bit 0
//   out_valid / out_ready : result handshake; result held until consumed
//   sum, cout, ovf        : W-bit sum, carry out of bit W-1, signed overflow
module cla_word_sequencer
  import cla_pkg::*;
#(
  parameter int N = CLA_N_DEFAULT,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum,
  output logic           cout,
  output logic           ovf
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [N-1:0]    slice_s;
  logic            slice_cout;
  logic            slice_cmsb;

  cla_slice #(.N(N)) u_slice (
    .a    (a_reg[N-1:0]),
    .b    (b_reg[N-1:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // NOTE: all state here is sequential and updated with non-blocking
  // assignments so every register samples pre-edge values consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is low only on the first cycle out of reset.
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          sum[idx*N +: N] <= slice_s;
          carry           <= slice_cout;
          a_reg           <= a_reg >> N;
          b_reg           <= b_reg >> N;
          idx             <= idx + IW'(1);
          if (idx == LAST) begin
            // The top slice's carries are the full-width carries.
            cout      <= slice_cout;
            ovf       <= slice_cmsb ^ slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : cla_word_sequencer

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer with N=4, K=4 (W=16).
module tb_cla_word_sequencer;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  cla_word_sequencer #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  function automatic logic [17:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
    int unsigned u;
    int          sv;
    logic        v;
    u  = int'(x) + int'(y) + int'(ci);
    sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
    v  = (sv > 32767) || (sv < -32768);
    return {v, u[16], u[15:0]};
  endfunction

  // Wait until out_valid with a cycle budget; returns cycles waited after accept.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input int hold, input logic inject);
    logic [17:0]  exp;
    int           lat;
    logic [W-1:0] s0;
    logic         c0, v0;
    exp = ref_add(x, y, ci);
    @(negedge clk);
    check({tag, " in_ready_before"}, in_ready, 1);
    in_valid = 1'b1; a = x; b = y; cin = ci;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " in_ready_run"}, in_ready, 0);
    wait_result(lat);
    check({tag, " latency"}, lat, K);
    check({tag, " sum"}, sum, exp[15:0]);
    check({tag, " cout"}, cout, exp[16]);
    check({tag, " ovf"}, ovf, exp[17]);
    s0 = sum; c0 = cout; v0 = ovf;
    for (int i = 0; i < hold; i++) begin
      if (inject) begin
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_in_ready"}, in_ready, 0);
      check({tag, " hold_result"}, {sum, cout, ovf}, {s0, c0, v0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post_valid"}, out_valid, 0);
    check({tag, " post_in_ready"}, in_ready, 1);
    check({tag, " post_result_kept"}, {sum, cout, ovf}, {s0, c0, v0});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [17:0]  exp;
    logic [W-1:0] x, y;
    logic         ci;
    int           lat;
    int           acc_cyc;
    int           prev_acc;
    int           guard;

    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset result", {sum, cout, ovf}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", in_ready, 1);

    run_op("basic",    16'h1234, 16'h1111, 1'b0, 0, 1'b0);
    run_op("ripple1",  16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op("ripple2",  16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    run_op("backpr",   16'h0F00, 16'h00F0, 1'b1, 5, 1'b1);
    run_op("aa55",     16'hAAAA, 16'h5555, 1'b0, 0, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst result", {sum, cout, ovf}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready after release", in_ready, 1);
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

    // Streaming: producer always valid, consumer always ready.
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 8; i++) begin
      x   = 16'($urandom);
      y   = 16'($urandom);
      ci  = 1'($urandom);
      exp = ref_add(x, y, ci);
      @(negedge clk);
      in_valid = 1'b1; a = x; b = y; cin = ci;
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("stream in_ready", in_ready, 1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (i > 0) check("stream spacing", acc_cyc - prev_acc, K + 2);
      prev_acc = acc_cyc;
      wait_result(lat);
      check("stream latency", lat, K);
      check("stream sum", sum, exp[15:0]);
      check("stream cout", cout, exp[16]);
      check("stream ovf", ovf, exp[17]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cla_word_sequencer

// File: doc/cla_word_sequencer.md
Name: cla_word_sequencer

Overview:
- Multi-cycle wide adder: computes a W-bit sum (W = N*K) by running one N-bit carry-lookahead slice K times, least-significant slice first.
- A carry register chains the slices between cycles.
- Valid/ready handshakes on both input and output; the result is held until it is consumed.
- Sits between the operand source and any wide-arithmetic consumer, so one narrow CLA slice serves full-width additions.

Parameters:
- N, 4, slice width in bits (N >= 1)
- K, 4, number of slices per operation (K >= 1); W = N*K is a derived localparam

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry into bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  carry out of bit W-1
- ovf  out  1  signed overflow (carry into bit W-1 XOR carry out of bit W-1)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=0, out_valid=0, sum=0, cout=0, ovf=0, slice index=0, carry reg=0.
- in_ready is a register. It goes to 1 on the first rising edge after rst_n deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept on in_valid && in_ready at a rising edge.
  - On accept: latch a, b into shift registers; carry reg <= cin; idx <= 0; in_ready <= 0; go to RUN.
- RUN (one slice per cycle):
  - Slice inputs are a_reg[N-1:0], b_reg[N-1:0] and carry reg.
  - On each edge: write the slice sum into sum[idx*N +: N]; carry reg <= slice cout; shift a_reg and b_reg right by N; idx <= idx+1.
  - On the edge where idx==K-1: capture cout <= slice cout and ovf <= slice cmsb XOR slice cout; out_valid <= 1; go to DONE.
- Latency: out_valid rises exactly K cycles after the accept edge. With K=1, the op is accepted at edge t and out_valid is 1 after edge t+1.
- DONE:
  - sum, cout, ovf and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid <= 0; in_ready <= 1; go to IDLE.
  - sum, cout and ovf keep their last values after the handshake.
- No overlap: in_ready=0 throughout RUN and DONE. in_valid is ignored there and operands are not sampled.
- Back-to-back: an output handshake at edge e makes the earliest next accept edge e+1.
- sum is not cleared at the start of an op. Intermediate values of sum during RUN are undefined to the consumer; only values with out_valid=1 count.
- Reset mid-operation: asserting rst_n at any point, including during RUN, returns every register to its reset value immediately. The partial result is discarded.
- Arithmetic: unsigned modulo 2^W for sum. cout and ovf are the exact full-width carry and signed overflow.
- out_valid and in_ready are never 1 simultaneously.

Decomposition:
- Shared package (cla_pkg): the FSM state enum (IDLE, RUN, DONE) and the default slice width constant.
- Sub-module cla_slice (combinational, parameter N):
  - Inputs: a, b, cin.
  - Outputs: s, cout (carry out of bit N-1) and cmsb (carry into bit N-1).
  - Internals: generate/propagate lookahead.
- cla_word_sequencer instantiates exactly one cla_slice. The index counter is $clog2(K) bits wide, minimum 1.

Test Plan:
- Test values use N=4, K=4.
- Basic add: a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Full carry ripple across all slices: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0xFFFF, cin=1 -> sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout and ovf stable and in_ready=0. A new in_valid with 0xAAAA+0x5555 during DONE is not accepted. After out_ready=1, in_ready returns 1 next cycle and 0xAAAA+0x5555 -> 0xFFFF, cout=0.
- Reset mid-RUN: assert rst_n low after 2 slice cycles of 0x1234+0x1111 -> out_valid, sum, cout, ovf and in_ready read 0 immediately. After release, in_ready=1 after one edge, and the next op 0x0F0F+0x00F1 -> 0x1000, cout=0.
- Throughput: 8 random ops, producer always valid and consumer always ready -> each result matches a reference model. Accept-to-accept spacing is exactly K+2 cycles.
